// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//
// Purpose:
//   Bundles the two buses the instruction memory loader sits between:
//   the incoming program byte stream (valid/ready handshake) and the
//   outgoing instruction RAM write port.
//
// Signals:
//   Byte_In     [7:0]        stream data byte
//   Byte_Valid               Byte_In valid
//   Byte_Ready               loader can accept a byte this cycle
//   Mem_Addr    [ADDR_W-1:0] instruction RAM write address
//   Mem_Data    [DATA_W-1:0] instruction RAM write data
//   Mem_Wr                   instruction RAM write strobe
//
// Modports:
//   master - host side: drives the byte stream and observes the RAM port
//   slave  - loader side: consumes the byte stream and drives the RAM port
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);

    logic [7:0]        Byte_In;
    logic              Byte_Valid;
    logic              Byte_Ready;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Data;
    logic              Mem_Wr;

    modport master (
        output Byte_In,
        output Byte_Valid,
        input  Byte_Ready,
        input  Mem_Addr,
        input  Mem_Data,
        input  Mem_Wr
    );

    modport slave (
        input  Byte_In,
        input  Byte_Valid,
        output Byte_Ready,
        output Mem_Addr,
        output Mem_Data,
        output Mem_Wr
    );

endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Writer-side counterpart to the instruction fetch path. Receives a
//   program image as a byte stream (header byte = word count N, then N
//   big-endian 16-bit words), writes the words sequentially into the
//   instruction RAM starting at address 0, and holds the CPU in reset
//   until a complete, valid image has been written.
//
// Ports:
//   Clk           system clock, rising edge
//   Rst           synchronous reset, active-low
//   Start         begin a load (pulse or level); ignored while Busy
//   bus           imem_loader_if.slave: byte stream in, RAM write port out
//   CPU_Rst       active-high reset to the CPU controller/PC
//   Busy          load in progress
//   Done          image loaded successfully
//   Err           load aborted
//   Words_Loaded  words written in the current/last load
//   OutState      current FSM state encoding, for debug
//
// Configuration:
//   IMEM_LOADER_CHECKSUM_EN - when defined, a trailing checksum byte (XOR
//   of all data bytes) is required after the last word; a mismatch ends
//   the load in ERR. When undefined the CHK state is never entered.
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 128
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    imem_loader_if.slave       bus,
    output logic               CPU_Rst,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    output logic [7:0]         Words_Loaded,
    output logic [2:0]         OutState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6,
        CHK   = 3'd7
    } state_t;

    // Header values above this limit are rejected; 9 bits so that a
    // MAX_WORDS of 256 would still compare correctly against an 8-bit byte.
    localparam logic [8:0]        MAX_WORDS_LIM = 9'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);

    state_t            state;
    state_t            next_state;

    logic              byte_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [7:0]        word_count;
    logic [7:0]        words_loaded;

    logic              next_ready;
    logic              next_wr;
    logic              next_busy;
    logic              next_done;
    logic              next_err;
    logic              next_cpu_rst;

    logic              byte_accept;
    logic              hdr_zero;
    logic              hdr_too_big;
    logic              last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        run_xor;
`endif

    assign byte_accept = bus.Byte_Valid && byte_ready;
    assign hdr_zero    = (bus.Byte_In == 8'd0);
    assign hdr_too_big = ({1'b0, bus.Byte_In} > MAX_WORDS_LIM);
    assign last_word   = ((words_loaded + 8'd1) == word_count);

    // Next-state logic. Every registered output is then decoded from the
    // next state, so outputs change on the same edge as OutState and
    // Byte_Ready never depends on Byte_Valid.
    always_comb begin
        next_state = state;

        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = HDR;
                end
            end
            HDR: begin
                if (byte_accept) begin
                    if (hdr_zero) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        next_state = CHK;
`else
                        next_state = DONE;
`endif
                    end else if (hdr_too_big) begin
                        next_state = ERR;
                    end else begin
                        next_state = HI;
                    end
                end
            end
            HI: begin
                if (byte_accept) begin
                    next_state = LO;
                end
            end
            LO: begin
                if (byte_accept) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = HI;
                end
            end
            DONE, ERR: begin
                if (Start) begin
                    next_state = HDR;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (byte_accept) begin
                    next_state = (bus.Byte_In == run_xor) ? DONE : ERR;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase

        next_ready   = (next_state == HDR) || (next_state == HI) ||
                       (next_state == LO)  || (next_state == CHK);
        next_wr      = (next_state == WRITE);
        next_busy    = (next_state == HDR) || (next_state == HI) ||
                       (next_state == LO)  || (next_state == WRITE) ||
                       (next_state == CHK);
        next_done    = (next_state == DONE);
        next_err     = (next_state == ERR);
        // The CPU only runs once a good image is in place.
        next_cpu_rst = (next_state != DONE);
    end

    // State and status register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            mem_wr     <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
            CPU_Rst    <= 1'b1;
        end else begin
            state      <= next_state;
            byte_ready <= next_ready;
            mem_wr     <= next_wr;
            Busy       <= next_busy;
            Done       <= next_done;
            Err        <= next_err;
            CPU_Rst    <= next_cpu_rst;
        end
    end

    // Word assembly, address and count bookkeeping. Mem_Addr and Mem_Data
    // only move outside WRITE, so they are stable during the strobe. The
    // address wraps naturally at 2**ADDR_W, which only happens after the
    // last word of a full-size image.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            mem_addr     <= '0;
            mem_data     <= '0;
            word_count   <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (Start) begin
                        mem_addr     <= '0;
                        words_loaded <= '0;
                    end
                end
                HDR: begin
                    if (byte_accept) begin
                        word_count <= bus.Byte_In;
                    end
                end
                HI: begin
                    if (byte_accept) begin
                        mem_data[DATA_W-1:8] <= bus.Byte_In;
                    end
                end
                LO: begin
                    if (byte_accept) begin
                        mem_data[7:0] <= bus.Byte_In;
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + 8'd1;
                    mem_addr     <= mem_addr + ADDR_ONE;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of data bytes only; the header is excluded and the
    // accumulator restarts whenever a new load begins.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            run_xor <= 8'd0;
        end else if ((state != HDR) && (next_state == HDR)) begin
            run_xor <= 8'd0;
        end else if (byte_accept && ((state == HI) || (state == LO))) begin
            run_xor <= run_xor ^ bus.Byte_In;
        end
    end
`endif

    assign bus.Byte_Ready = byte_ready;
    assign bus.Mem_Wr     = mem_wr;
    assign bus.Mem_Addr   = mem_addr;
    assign bus.Mem_Data   = mem_data;
    assign Words_Loaded   = words_loaded;
    assign OutState       = state;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Purpose:
//   Directed self-checking bench for imem_loader. A small RAM model in the
//   bench captures every write strobe; the initial block drives a linear
//   sequence of loads and compares outputs and RAM contents against
//   hand-computed values. Honours IMEM_LOADER_CHECKSUM_EN when defined.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] words_loaded;
    logic [2:0] out_state;

    int         checks    = 0;
    int         errors    = 0;
    int         last_wait = 0;
    int         wr_count  = 0;
    int         bad_wr    = 0;
    logic [15:0] ram [0:127];
    logic [7:0]  v;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int EXTRA_WR = 2;
`else
    localparam int EXTRA_WR = 0;
`endif

    imem_loader_if #(.ADDR_W(7), .DATA_W(16)) bus ();

    imem_loader #(
        .ADDR_W    (7),
        .DATA_W    (16),
        .MAX_WORDS (128)
    ) dut (
        .Clk          (clk),
        .Rst          (rst),
        .Start        (start),
        .bus          (bus),
        .CPU_Rst      (cpu_rst),
        .Busy         (busy),
        .Done         (done),
        .Err          (err),
        .Words_Loaded (words_loaded),
        .OutState     (out_state)
    );

    always #5 clk = ~clk;

    // Instruction RAM model plus a watch for strobes outside WRITE.
    always @(posedge clk) begin
        if (bus.Mem_Wr) begin
            ram[bus.Mem_Addr] <= bus.Mem_Data;
            wr_count          <= wr_count + 1;
            if (out_state != 3'd4) begin
                bad_wr <= bad_wr + 1;
            end
        end
    end

    // Hard stop in case something wedges the sequence.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a byte and hold it until the loader takes it. Byte_Ready seen
    // just after an edge is what the next edge will use.
    task automatic apply_byte(input logic [7:0] b);
        int  n  = 0;
        bit  ok = 1'b0;
        bus.Byte_In    = b;
        bus.Byte_Valid = 1'b1;
        while ((n < 20) && !ok) begin
            ok = bus.Byte_Ready;
            tick();
            n++;
        end
        last_wait = n;
        check_output("byte_accept", 32'(ok), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Close a load after the final word's bytes have been sent.
    task automatic finish_load(input logic [7:0] cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
        apply_byte(cs);
`else
        bus.Byte_In    = cs;
        bus.Byte_Valid = 1'b0;
        tick();
`endif
        bus.Byte_Valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        start          = 1'b0;
        bus.Byte_In    = 8'h00;
        bus.Byte_Valid = 1'b0;

        // ---------------- reset ----------------
        tick();
        tick();
        check_output("rst_cpu_rst", 32'(cpu_rst), 1);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_done", 32'(done), 0);
        check_output("rst_err", 32'(err), 0);
        check_output("rst_state", 32'(out_state), 0);
        check_output("rst_ready", 32'(bus.Byte_Ready), 0);
        check_output("rst_mem_wr", 32'(bus.Mem_Wr), 0);
        check_output("rst_addr", 32'(bus.Mem_Addr), 0);
        check_output("rst_data", 32'(bus.Mem_Data), 0);
        check_output("rst_words", 32'(words_loaded), 0);
        rst = 1'b1;
        tick();
        check_output("idle_hold", 32'(out_state), 0);

        // ---------------- 2-word gapless load ----------------
        $display("[TB] two-word load");
        pulse_start();
        check_output("hdr_state", 32'(out_state), 1);
        check_output("hdr_busy", 32'(busy), 1);
        check_output("hdr_ready", 32'(bus.Byte_Ready), 1);
        apply_byte(8'h02);
        apply_byte(8'h12);
        apply_byte(8'h34);
        check_output("w0_strobe", 32'(bus.Mem_Wr), 1);
        check_output("w0_addr", 32'(bus.Mem_Addr), 0);
        check_output("w0_data", 32'(bus.Mem_Data), 32'h1234);
        check_output("w0_ready", 32'(bus.Byte_Ready), 0);
        apply_byte(8'hAB);
        check_output("bp_wait", 32'(last_wait), 2);
        apply_byte(8'hCD);
        check_output("w1_addr", 32'(bus.Mem_Addr), 1);
        check_output("w1_data", 32'(bus.Mem_Data), 32'hABCD);
        finish_load(8'h40);
        check_output("l2_done", 32'(done), 1);
        check_output("l2_cpu_rst", 32'(cpu_rst), 0);
        check_output("l2_busy", 32'(busy), 0);
        check_output("l2_words", 32'(words_loaded), 2);
        check_output("l2_state", 32'(out_state), 5);
        check_output("l2_ram0", 32'(ram[0]), 32'h1234);
        check_output("l2_ram1", 32'(ram[1]), 32'hABCD);
        check_output("l2_wr_count", 32'(wr_count), 2);

        // ---------------- reload with a 5-cycle gap mid-word ----------------
        $display("[TB] reload with gap");
        pulse_start();
        check_output("reload_cpu_rst", 32'(cpu_rst), 1);
        check_output("reload_words", 32'(words_loaded), 0);
        apply_byte(8'h02);
        apply_byte(8'h56);
        bus.Byte_Valid = 1'b0;
        start          = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        start = 1'b0;
        check_output("gap_state", 32'(out_state), 3);
        apply_byte(8'h78);
        apply_byte(8'h9A);
        apply_byte(8'hBC);
        finish_load(8'h08);
        check_output("gap_done", 32'(done), 1);
        check_output("gap_ram0", 32'(ram[0]), 32'h5678);
        check_output("gap_ram1", 32'(ram[1]), 32'h9ABC);
        check_output("gap_wr_count", 32'(wr_count), 4);

        // ---------------- oversize header, then empty image ----------------
        $display("[TB] oversize header");
        pulse_start();
        apply_byte(8'h81);
        bus.Byte_Valid = 1'b0;
        check_output("big_err", 32'(err), 1);
        check_output("big_cpu_rst", 32'(cpu_rst), 1);
        check_output("big_state", 32'(out_state), 6);
        check_output("big_busy", 32'(busy), 0);
        tick();
        check_output("big_wr_count", 32'(wr_count), 4);
        pulse_start();
        apply_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_output("zero_chk_state", 32'(out_state), 7);
        apply_byte(8'h00);
`endif
        bus.Byte_Valid = 1'b0;
        check_output("zero_done", 32'(done), 1);
        check_output("zero_err", 32'(err), 0);
        check_output("zero_words", 32'(words_loaded), 0);
        check_output("zero_cpu_rst", 32'(cpu_rst), 0);

        // ---------------- full 128-word image ----------------
        $display("[TB] max image");
        pulse_start();
        apply_byte(8'h80);
        for (int i = 0; i < 128; i++) begin
            v = 8'(i);
            apply_byte(v);
            apply_byte(~v);
        end
        finish_load(8'h00);
        check_output("max_done", 32'(done), 1);
        check_output("max_words", 32'(words_loaded), 128);
        check_output("max_addr_wrap", 32'(bus.Mem_Addr), 0);
        check_output("max_ram0", 32'(ram[0]), 32'h00FF);
        check_output("max_ram64", 32'(ram[64]), 32'h40BF);
        check_output("max_ram127", 32'(ram[127]), 32'h7F80);
        check_output("max_wr_count", 32'(wr_count), 132);

        // ---------------- reset in the middle of a 4-word load ----------------
        $display("[TB] reset mid-load");
        pulse_start();
        apply_byte(8'h04);
        apply_byte(8'h11);
        apply_byte(8'h11);
        apply_byte(8'h22);
        apply_byte(8'h22);
        apply_byte(8'h33);
        apply_byte(8'h33);
        bus.Byte_Valid = 1'b0;
        tick();
        check_output("mid_words", 32'(words_loaded), 3);
        check_output("mid_state", 32'(out_state), 2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_output("mid_rst_state", 32'(out_state), 0);
        check_output("mid_rst_words", 32'(words_loaded), 0);
        check_output("mid_rst_cpu_rst", 32'(cpu_rst), 1);
        check_output("mid_rst_busy", 32'(busy), 0);
        check_output("mid_ram0", 32'(ram[0]), 32'h1111);
        check_output("mid_ram1", 32'(ram[1]), 32'h2222);
        check_output("mid_ram2", 32'(ram[2]), 32'h3333);
        check_output("mid_ram3", 32'(ram[3]), 32'h03FC);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---------------- checksum pass and fail ----------------
        $display("[TB] checksum");
        pulse_start();
        apply_byte(8'h01);
        apply_byte(8'h12);
        apply_byte(8'h34);
        bus.Byte_Valid = 1'b0;
        tick();
        check_output("chk_state", 32'(out_state), 7);
        apply_byte(8'h26);
        bus.Byte_Valid = 1'b0;
        check_output("chk_pass_done", 32'(done), 1);
        pulse_start();
        apply_byte(8'h01);
        apply_byte(8'h12);
        apply_byte(8'h34);
        apply_byte(8'h27);
        bus.Byte_Valid = 1'b0;
        check_output("chk_fail_err", 32'(err), 1);
        check_output("chk_fail_cpu_rst", 32'(cpu_rst), 1);
`endif

        tick();
        check_output("total_wr_count", 32'(wr_count), 32'(135 + EXTRA_WR));
        check_output("stray_mem_wr", 32'(bad_wr), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the instruction fetch path. Receives a program image as a byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them sequentially into the instruction RAM that the CPU controller fetches from.
- Holds the CPU in reset while loading. Releases it only after a complete, valid image has been written.

Parameters:
- ADDR_W, 7, instruction memory address width; matches the 7-bit PC.
- DATA_W, 16, instruction word width; fixed at 2 bytes per word.
- MAX_WORDS, 128, largest accepted image length (2**ADDR_W).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous reset, active-low.
- Start  in  1  begin a load; one-cycle pulse or level.
- Byte_In  in  8  stream data byte.
- Byte_Valid  in  1  Byte_In valid.
- Byte_Ready  out  1  loader can accept a byte this cycle.
- Mem_Addr  out  ADDR_W  instruction RAM write address.
- Mem_Data  out  DATA_W  instruction RAM write data.
- Mem_Wr  out  1  instruction RAM write strobe, one cycle per word.
- CPU_Rst  out  1  active-high reset to the CPU controller/PC.
- Busy  out  1  load in progress.
- Done  out  1  image loaded successfully.
- Err  out  1  load aborted.
- Words_Loaded  out  8  count of words written in current/last load.
- OutState  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset (Rst=0 at a rising edge):
  - State goes to IDLE.
  - CPU_Rst=1; Byte_Ready=0, Mem_Wr=0, Busy=0, Done=0, Err=0.
  - Mem_Addr=0, Mem_Data=0, Words_Loaded=0.
  - RAM contents are not touched.
- Handshake: a byte is accepted on a rising edge with Byte_Valid=1 and Byte_Ready=1. Byte_Ready is a registered function of state only, never of Byte_Valid.
- States (OutState encoding): IDLE=0, HDR=1, HI=2, LO=3, WRITE=4, DONE=5, ERR=6, CHK=7 (CHK used only with the optional feature).
- IDLE:
  - Start=1 -> HDR. Busy=1, CPU_Rst=1, Done=0, Err=0, Words_Loaded=0, Mem_Addr=0.
- HDR (Byte_Ready=1): the accepted byte is the word count N.
  - N=0 -> DONE; nothing written.
  - N>MAX_WORDS -> ERR.
  - Otherwise latch N and go to HI.
- HI (Byte_Ready=1): accepted byte -> Mem_Data[15:8]; go to LO.
- LO (Byte_Ready=1): accepted byte -> Mem_Data[7:0]; go to WRITE.
- WRITE (Byte_Ready=0): Mem_Wr=1 for exactly this cycle, with Mem_Addr and Mem_Data stable.
  - On exit, Words_Loaded increments.
  - Mem_Addr increments with wrap (127+1 -> 0; only reachable as the final word of a 128-word image).
  - If Words_Loaded+1==N -> DONE (or CHK when the option is on); else -> HI.
- Write latency: Mem_Wr asserts the cycle after the low byte is accepted. Peak throughput is 1 word per 3 cycles.
- DONE: Busy=0, Done=1, CPU_Rst=0 (CPU runs). Start=1 -> HDR (reload); CPU_Rst reasserts the same cycle HDR is entered.
- ERR: Busy=0, Err=1, CPU_Rst=1 (CPU stays in reset). Start=1 -> HDR.
- Start while Busy is ignored.
- Byte_Valid while Byte_Ready=0 is ignored; the byte is not consumed and the source must hold it.
- Rst mid-load returns to IDLE. Words already written stay in RAM; Words_Loaded clears to 0.
- Mem_Wr is never asserted outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- Defined:
  - After the final WRITE -> CHK (Byte_Ready=1).
  - The accepted byte is compared against the running XOR of every data byte (header excluded); the running XOR clears on entry to HDR.
  - Match -> DONE; mismatch -> ERR. Words already written stay in RAM.
  - N=0 also passes through CHK, expecting 8'h00.
- Undefined: no CHK state; final WRITE -> DONE directly; state code 7 is unreachable.

Test Plan:
- Reset: Rst=0 for 2 cycles -> CPU_Rst=1, Busy=Done=Err=0, OutState=0, Byte_Ready=0.
- Load 2 words: Start, then bytes 02, 12, 34, AB, CD with Byte_Valid held high -> Mem_Wr pulses at addr 0 data 16'h1234, then addr 1 data 16'hABCD. Done=1, CPU_Rst=0, Words_Loaded=2.
- Backpressure and gaps:
  - Byte_Valid held high during WRITE -> no byte consumed; the byte is accepted in HI the following cycle.
  - Byte_Valid low for 5 cycles mid-word -> same final RAM contents as the gapless load.
- Header 8'h81 (129) -> ERR, Err=1, CPU_Rst=1, no Mem_Wr. A subsequent Start with header 00 -> DONE, Words_Loaded=0.
- Max image and reset:
  - Header 8'h80 plus 256 data bytes -> 128 writes, addr 0..127; Done=1.
  - Rst=0 after 3 words of a 4-word load -> IDLE, Words_Loaded=0, CPU_Rst=1; RAM words 0..2 retain written values.
- With IMEM_LOADER_CHECKSUM_EN, 1-word image 12, 34:
  - Checksum 8'h26 -> DONE.
  - Checksum 8'h27 -> ERR, CPU_Rst=1.
